// File: rtl/micro_op_sequencer.sv
// Buffers multi-micro-op instructions and issues up to OUT_WIDTH micro-ops per
// cycle in program order, splitting instructions across cycles as needed.
module micro_op_sequencer #(
  parameter int OP_BITS   = 64,
  parameter int MAX_MOP   = 3,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 4,
  localparam int MID_BITS = (MAX_MOP > 1) ? $clog2(MAX_MOP) : 1,
  localparam int CNT_BITS = $clog2(MAX_MOP + 1),
  localparam int OCC_BITS = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [CNT_BITS-1:0]           inCount,
  input  logic [MAX_MOP*OP_BITS-1:0]    inOps,
  output logic [OUT_WIDTH-1:0]          outValid,
  output logic [OUT_WIDTH*OP_BITS-1:0]  outOp,
  output logic [OUT_WIDTH*MID_BITS-1:0] outMid,
  output logic [OUT_WIDTH-1:0]          outLast,
  output logic [OUT_WIDTH-1:0]          outSplit,
  input  logic                          outReady,
  output logic [OCC_BITS-1:0]           occupancy
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_BITS-1:0] occ_q, occ_d;
  logic [MID_BITS-1:0] cur_q, cur_d;

  logic [CNT_BITS-1:0] cnt_q [DEPTH];
  logic [OP_BITS-1:0]  ops_q [DEPTH][MAX_MOP];

  logic                cnt_ok;
  logic                push;
  logic                fire;
  logic [31:0]         ent;
  logic [MID_BITS-1:0] mid;
  logic [PTR_BITS-1:0] idx;
  logic [CNT_BITS-1:0] cnt;
  logic                lst;
  logic [MID_BITS-1:0] cur_end;
  logic [OCC_BITS-1:0] pop_n;

  // Readiness looks only at current occupancy; a same-cycle pop never frees a slot early.
  assign inReady   = (occ_q < OCC_BITS'(DEPTH)) && !flush && rst;
  assign cnt_ok    = (inCount != '0) && (inCount <= CNT_BITS'(MAX_MOP));
  assign push      = inValid && inReady && cnt_ok;
  assign fire      = outReady && outValid[0];
  assign occupancy = occ_q;

  // Walk from (head, cursor) across entries, filling lanes in program order.
  always_comb begin
    ent      = '0;
    mid      = cur_q;
    idx      = '0;
    cnt      = '0;
    lst      = 1'b0;
    outValid = '0;
    outOp    = '0;
    outMid   = '0;
    outLast  = '0;
    outSplit = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      idx = head_q + ent[PTR_BITS-1:0];
      cnt = cnt_q[idx];
      lst = (CNT_BITS'(mid) == (cnt - CNT_BITS'(1)));
      if (!flush && (ent < 32'(occ_q))) begin
        outValid[k]                      = 1'b1;
        outOp[k*OP_BITS +: OP_BITS]      = ops_q[idx][mid];
        outMid[k*MID_BITS +: MID_BITS]   = mid;
        outLast[k]                       = lst;
        outSplit[k]                      = (cnt > CNT_BITS'(1));
        if (lst) begin
          ent = ent + 32'd1;
          mid = '0;
        end else begin
          mid = mid + MID_BITS'(1);
        end
      end
    end
    cur_end = mid;
    pop_n   = OCC_BITS'(ent);
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cur_d  = cur_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      cur_d  = '0;
    end else begin
      if (fire) begin
        head_d = head_q + PTR_BITS'(pop_n);
        cur_d  = cur_end;
      end
      if (push) begin
        tail_d = tail_q + PTR_BITS'(1);
      end
      occ_d = occ_q + OCC_BITS'(push) - (fire ? pop_n : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cur_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cur_q  <= cur_d;
    end
  end

  // Entry payloads carry no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      cnt_q[tail_q] <= inCount;
      for (int j = 0; j < MAX_MOP; j++) begin
        ops_q[tail_q][j] <= inOps[j*OP_BITS +: OP_BITS];
      end
    end
  end

endmodule

// File: tb/tb_micro_op_sequencer.sv
// Bench for micro_op_sequencer: directed vector table, corner sequences and a
// randomized run against a flat micro-op queue model.
module tb_micro_op_sequencer;

  localparam int OP_BITS   = 16;
  localparam int MAX_MOP   = 4;
  localparam int OUT_WIDTH = 2;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inCount;
  logic [63:0] inOps;
  logic [1:0]  outValid;
  logic [31:0] outOp;
  logic [3:0]  outMid;
  logic [1:0]  outLast;
  logic [1:0]  outSplit;
  logic        outReady;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  micro_op_sequencer #(
    .OP_BITS(OP_BITS), .MAX_MOP(MAX_MOP), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inCount(inCount), .inOps(inOps),
    .outValid(outValid), .outOp(outOp), .outMid(outMid), .outLast(outLast),
    .outSplit(outSplit), .outReady(outReady), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  // Reference: every buffered micro-op not yet emitted, in program order.
  typedef struct {
    logic [15:0] op;
    int          mid;
    bit          last;
    bit          split;
  } mop_t;
  mop_t mq[$];

  typedef struct {
    bit          in_v;
    int          cnt;
    logic [7:0]  tag;
    bit          out_r;
    logic [1:0]  vld;
    logic [31:0] ops;
    logic [3:0]  mid;
    logic [1:0]  last;
    logic [1:0]  split;
    int          occ;
    bit          rdy;
  } vec_t;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  function automatic logic [63:0] tagops(logic [7:0] tag);
    logic [63:0] o;
    for (int j = 0; j < MAX_MOP; j++) o[j*16 +: 16] = {tag, 8'(j)};
    return o;
  endfunction

  task automatic apply(bit v, int c, logic [63:0] ops, bit r, bit f);
    @(negedge clk);
    inValid  = v;
    inCount  = 3'(c);
    inOps    = ops;
    outReady = r;
    flush    = f;
    #1;
  endtask

  task automatic model_check();
    logic [1:0]  ev, el, es;
    logic [31:0] eo;
    logic [3:0]  em;
    bit          er;
    ev = '0; el = '0; es = '0; eo = '0; em = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (!flush && k < mq.size()) begin
        ev[k]         = 1'b1;
        eo[k*16 +: 16] = mq[k].op;
        em[k*2 +: 2]   = 2'(mq[k].mid);
        el[k]         = mq[k].last;
        es[k]         = mq[k].split;
      end
    end
    er = (model_occ() < DEPTH) && !flush;
    chk("m_valid", 64'(outValid), 64'(ev));
    chk("m_op",    64'(outOp),    64'(eo));
    chk("m_mid",   64'(outMid),   64'(em));
    chk("m_last",  64'(outLast),  64'(el));
    chk("m_split", 64'(outSplit), 64'(es));
    chk("m_occ",   64'(occupancy), 64'(model_occ()));
    chk("m_rdy",   64'(inReady),  64'(er));
  endtask

  task automatic model_update();
    bit   rdy;
    mop_t m;
    int   n;
    rdy = (model_occ() < DEPTH) && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (outReady) begin
        for (int k = 0; k < OUT_WIDTH; k++) if (mq.size() > 0) void'(mq.pop_front());
      end
      n = int'(inCount);
      if (inValid && rdy && n >= 1 && n <= MAX_MOP) begin
        for (int j = 0; j < n; j++) begin
          m.op    = inOps[j*16 +: 16];
          m.mid   = j;
          m.last  = (j == n - 1);
          m.split = (n > 1);
          mq.push_back(m);
        end
      end
    end
  endtask

  task automatic step(bit v, int c, logic [63:0] ops, bit r, bit f);
    apply(v, c, ops, r, f);
    model_check();
    model_update();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  vec_t        tbl[12];
  logic [31:0] snap;

  initial begin
    tbl[0]  = '{1'b1, 3, 8'hA1, 1'b1, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};
    tbl[1]  = '{1'b0, 0, 8'h00, 1'b1, 2'b11, 32'hA101A100, 4'h4, 2'b00, 2'b11, 1, 1'b1};
    tbl[2]  = '{1'b0, 0, 8'h00, 1'b1, 2'b01, 32'h0000A102, 4'h2, 2'b01, 2'b01, 1, 1'b1};
    tbl[3]  = '{1'b0, 0, 8'h00, 1'b1, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};
    tbl[4]  = '{1'b1, 1, 8'hB1, 1'b0, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};
    tbl[5]  = '{1'b1, 3, 8'hC1, 1'b0, 2'b01, 32'h0000B100, 4'h0, 2'b01, 2'b00, 1, 1'b1};
    tbl[6]  = '{1'b0, 0, 8'h00, 1'b1, 2'b11, 32'hC100B100, 4'h0, 2'b01, 2'b10, 2, 1'b1};
    tbl[7]  = '{1'b0, 0, 8'h00, 1'b1, 2'b11, 32'hC102C101, 4'h9, 2'b10, 2'b11, 1, 1'b1};
    tbl[8]  = '{1'b0, 0, 8'h00, 1'b1, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};
    tbl[9]  = '{1'b1, 0, 8'hD1, 1'b1, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};
    tbl[10] = '{1'b1, 5, 8'hD2, 1'b1, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};
    tbl[11] = '{1'b0, 0, 8'h00, 1'b1, 2'b00, 32'h0,        4'h0, 2'b00, 2'b00, 0, 1'b1};

    rst = 1'b0; flush = 1'b0; inValid = 1'b0; inCount = '0; inOps = '0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_rdy",   64'(inReady),  64'd0);
    chk("rst_occ",   64'(occupancy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rel_rdy", 64'(inReady), 64'd1);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].in_v, tbl[i].cnt, tagops(tbl[i].tag), tbl[i].out_r, 1'b0);
      chk($sformatf("t%0d_valid", i), 64'(outValid),  64'(tbl[i].vld));
      chk($sformatf("t%0d_op", i),    64'(outOp),     64'(tbl[i].ops));
      chk($sformatf("t%0d_mid", i),   64'(outMid),    64'(tbl[i].mid));
      chk($sformatf("t%0d_last", i),  64'(outLast),   64'(tbl[i].last));
      chk($sformatf("t%0d_split", i), 64'(outSplit),  64'(tbl[i].split));
      chk($sformatf("t%0d_occ", i),   64'(occupancy), 64'(tbl[i].occ));
      chk($sformatf("t%0d_rdy", i),   64'(inReady),   64'(tbl[i].rdy));
      model_check();
      model_update();
    end

    // Full buffer with a stalled consumer, then release.
    for (int i = 0; i < 4; i++) step(1'b1, 2, rnd64(), 1'b0, 1'b0);
    step(1'b1, 2, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_rdy", 64'(inReady), 64'd0);
    snap = outOp;
    step(1'b1, 2, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    chk("hold_op", 64'(outOp), 64'(snap));
    step(1'b1, 2, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
    chk("pop_no_push_rdy", 64'(inReady), 64'd0);
    step(1'b1, 2, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
    chk("after_pop_rdy", 64'(inReady), 64'd1);
    repeat (6) step(1'b0, 0, 64'd0, 1'b1, 1'b0);

    // Flush mid-instruction.
    step(1'b1, 3, rnd64(), 1'b0, 1'b0);
    step(1'b0, 0, 64'd0, 1'b1, 1'b0);
    step(1'b1, 2, rnd64(), 1'b1, 1'b1);
    chk("flush_valid", 64'(outValid), 64'd0);
    chk("flush_rdy", 64'(inReady), 64'd0);
    step(1'b0, 0, 64'd0, 1'b1, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_no_a2", 64'(outValid), 64'd0);

    // Asynchronous reset while an instruction is partly pending.
    step(1'b1, 3, rnd64(), 1'b0, 1'b0);
    step(1'b0, 0, 64'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(outValid), 64'd0);
    chk("arst_rdy", 64'(inReady), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_rel_rdy", 64'(inReady), 64'd1);
    step(1'b1, 2, 64'h0000_0000_2222_1111, 1'b1, 1'b0);
    step(1'b0, 0, 64'd0, 1'b1, 1'b0);
    chk("arst_mid0", 64'(outMid[1:0]), 64'd0);
    chk("arst_op0", 64'(outOp[15:0]), 64'h1111);

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 5)), rnd64(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    repeat (6) step(1'b0, 0, 64'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
